// File: rtl/wallclock_pkg.sv
// Shared constants and BCD helpers for the wall-clock controller.
package wallclock_pkg;

    typedef logic [7:0] bcd_t;
    typedef logic [1:0] mode_t;
    typedef logic [5:0] blank_t;

    // FSM state codes; the mode output reports these directly.
    localparam mode_t StRun     = 2'd0;
    localparam mode_t StSetHour = 2'd1;
    localparam mode_t StSetMin  = 2'd2;
    localparam mode_t StSetSec  = 2'd3;

    // Inclusive upper limits of the BCD fields.
    localparam bcd_t HOUR_MAX   = 8'h23;
    localparam bcd_t MINSEC_MAX = 8'h59;

    // Digit blank masks, ordered {hour_t, hour_u, min_t, min_u, sec_t, sec_u}.
    localparam blank_t BlankNone = 6'b000000;
    localparam blank_t BlankHour = 6'b110000;
    localparam blank_t BlankMin  = 6'b001100;
    localparam blank_t BlankSec  = 6'b000011;

    // Next BCD value, wrapping from max back to 00.
    function automatic bcd_t bcd_inc(input bcd_t value, input bcd_t max);
        bcd_t result;
        if (value == max) begin
            result = 8'h00;
        end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

    // Previous BCD value, wrapping from 00 up to max.
    function automatic bcd_t bcd_dec(input bcd_t value, input bcd_t max);
        bcd_t result;
        if (value == 8'h00) begin
            result = max;
        end else if (value[3:0] == 4'd0) begin
            result = {value[7:4] - 4'd1, 4'd9};
        end else begin
            result = {value[7:4], value[3:0] - 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/wallclock_if.sv
// Pulse inputs and display outputs of the wall-clock controller.
interface wallclock_if;
    import wallclock_pkg::*;

    logic   tick_1s;
    logic   btn_mode;
    logic   btn_inc;
    logic   btn_dec;
    bcd_t   hour;
    bcd_t   min;
    bcd_t   sec;
    mode_t  mode;
    blank_t digit_blank;
    logic   day_pulse;

    // Driver side: produces the ticks and button pulses, observes the display.
    modport master (
        output tick_1s, btn_mode, btn_inc, btn_dec,
        input  hour, min, sec, mode, digit_blank, day_pulse
    );

    // Controller side.
    modport slave (
        input  tick_1s, btn_mode, btn_inc, btn_dec,
        output hour, min, sec, mode, digit_blank, day_pulse
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with run carry-in, manual inc/dec and a wrap pulse.
module bcd_mod_counter
    import wallclock_pkg::*;
#(
    parameter bcd_t MAX       = 8'h59,
    parameter bcd_t RESET_VAL = 8'h00
) (
    input  logic clk,
    input  logic reset,
    input  logic carry_en,
    input  logic inc,
    input  logic dec,
    output bcd_t value,
    output logic wrap
);

    bcd_t value_q, value_d;

    // Carry-in and inc both count up; a conflicting inc/dec pair is a no-op.
    always_comb begin
        value_d = value_q;
        if (carry_en || (inc && !dec)) begin
            value_d = bcd_inc(value_q, MAX);
        end else if (dec && !inc) begin
            value_d = bcd_dec(value_q, MAX);
        end
    end

    // Field register.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= RESET_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    // Only a run carry produces a wrap, so manual edits never ripple outward.
    assign wrap  = carry_en && (value_q == MAX);

endmodule

// File: rtl/wallclock_ctrl.sv
// Wall-clock time keeper with a mode FSM for setting hour, minute and second.
module wallclock_ctrl
    import wallclock_pkg::*;
#(
    parameter bcd_t RESET_HOUR = 8'h00,
    parameter bcd_t RESET_MIN  = 8'h00
) (
    input logic        clk,
    input logic        reset,
    wallclock_if.slave bus
);

    mode_t  state_q, state_d;
    logic   blink_q, blink_d;
    logic   day_q;
    blank_t blank;

    logic in_set;
    logic run_tick;
    logic edit_ok;
    logic edit_inc;
    logic edit_dec;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;
    bcd_t sec_val;
    bcd_t min_val;
    bcd_t hour_val;

    assign in_set   = (state_q != StRun);
    assign run_tick = !in_set && bus.tick_1s;
    // A mode press wins over inc/dec; inc and dec together cancel.
    assign edit_ok  = in_set && !bus.btn_mode && (bus.btn_inc ^ bus.btn_dec);
    assign edit_inc = edit_ok && bus.btn_inc;
    assign edit_dec = edit_ok && bus.btn_dec;

    bcd_mod_counter #(
        .MAX       (MINSEC_MAX),
        .RESET_VAL (8'h00)
    ) u_sec (
        .clk      (clk),
        .reset    (reset),
        .carry_en (run_tick),
        .inc      (edit_inc && (state_q == StSetSec)),
        .dec      (edit_dec && (state_q == StSetSec)),
        .value    (sec_val),
        .wrap     (sec_wrap)
    );

    bcd_mod_counter #(
        .MAX       (MINSEC_MAX),
        .RESET_VAL (RESET_MIN)
    ) u_min (
        .clk      (clk),
        .reset    (reset),
        .carry_en (sec_wrap),
        .inc      (edit_inc && (state_q == StSetMin)),
        .dec      (edit_dec && (state_q == StSetMin)),
        .value    (min_val),
        .wrap     (min_wrap)
    );

    bcd_mod_counter #(
        .MAX       (HOUR_MAX),
        .RESET_VAL (RESET_HOUR)
    ) u_hour (
        .clk      (clk),
        .reset    (reset),
        .carry_en (min_wrap),
        .inc      (edit_inc && (state_q == StSetHour)),
        .dec      (edit_dec && (state_q == StSetHour)),
        .value    (hour_val),
        .wrap     (hour_wrap)
    );

    // Mode FSM: each mode press steps to the next field, then back to RUN.
    always_comb begin
        state_d = state_q;
        if (bus.btn_mode) begin
            case (state_q)
                StRun:     state_d = StSetHour;
                StSetHour: state_d = StSetMin;
                StSetMin:  state_d = StSetSec;
                default:   state_d = StRun;
            endcase
        end
    end

    // Blink phase: cleared on state change or edit, toggled by ticks while setting.
    always_comb begin
        blink_d = blink_q;
        if (bus.btn_mode) begin
            blink_d = 1'b0;
        end else if (in_set && (bus.btn_inc || bus.btn_dec)) begin
            blink_d = 1'b0;
        end else if (in_set && bus.tick_1s) begin
            blink_d = !blink_q;
        end
    end

    // State, blink and midnight pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            blink_q <= 1'b0;
            day_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
            day_q   <= hour_wrap;
        end
    end

    // Blank the selected field's digits during the off phase of the blink.
    always_comb begin
        blank = BlankNone;
        if (blink_q) begin
            case (state_q)
                StSetHour: blank = BlankHour;
                StSetMin:  blank = BlankMin;
                StSetSec:  blank = BlankSec;
                default:   blank = BlankNone;
            endcase
        end
    end

    assign bus.hour        = hour_val;
    assign bus.min         = min_val;
    assign bus.sec         = sec_val;
    assign bus.mode        = state_q;
    assign bus.digit_blank = blank;
    assign bus.day_pulse   = day_q;

endmodule
